pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, giving the PC and target width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value after reset.
REQ-003 The block SHALL have parameter INSTR_BYTES, default 4, giving the PC increment per accepted fetch; it SHALL be a power of two.
REQ-004 clk_i  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 en_i  input  1  run enable.
REQ-007 halt_i  input  1  halt request.
REQ-008 fetch_ready_i  input  1  the fetch stage accepts fetch_pc_o.
REQ-009 fetch_valid_o  output  1  fetch_pc_o is valid.
REQ-010 fetch_pc_o  output  DATAWIDTH  address to fetch; equals the internal PC register.
REQ-011 br_valid_i  input  1  a branch is resolved this cycle.
REQ-012 br_cond_i  input  1  taken flag, driven by the comparator out_o.
REQ-013 br_target_i  input  DATAWIDTH  branch target address.
REQ-014 flush_o  output  1  one-cycle pulse that kills younger in-flight instructions.
REQ-015 misalign_o  output  1  sticky flag: a taken target was misaligned.
REQ-016 taken_cnt_o  output  16  saturating count of taken branches.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, FLUSH and HALTED; fetch_valid_o SHALL be 1 only in RUN.
REQ-018 IDLE SHALL go to RUN on the cycle after en_i=1 is sampled.
REQ-019 In RUN with en_i=0 (and no halt or taken branch), the next state SHALL be IDLE, with the PC retained.
REQ-020 In RUN, fetch_valid_o&&fetch_ready_i SHALL advance PC by INSTR_BYTES modulo 2^DATAWIDTH; 'hFFFF_FFFC+4 SHALL give 0.
REQ-021 In RUN with fetch_ready_i=0, fetch_pc_o SHALL hold stable, and fetch_valid_o SHALL stay 1 unless a taken branch, halt_i or en_i=0 intervenes.
REQ-022 A taken branch SHALL be br_valid_i&&br_cond_i sampled in RUN or FLUSH; in IDLE and HALTED, br_valid_i SHALL be ignored.
REQ-023 On a taken branch, the next PC SHALL be br_target_i with its low log2(INSTR_BYTES) bits cleared, taking priority over the increment even when a handshake occurs in the same cycle.
REQ-024 If those low bits are nonzero, misalign_o SHALL set on the next cycle and stay set until reset.
REQ-025 A taken branch SHALL register flush_o=1 for exactly the next cycle and move the FSM to FLUSH for one cycle, after which it returns to RUN.
REQ-026 A taken branch that arrives while in FLUSH SHALL redirect again, pulse flush_o again and stay in FLUSH one more cycle.
REQ-027 br_valid_i=1 with br_cond_i=0 SHALL have no effect.
REQ-028 halt_i=1 in RUN or FLUSH SHALL make the next state HALTED, taking precedence over FLUSH.
REQ-029 Under REQ-028, a handshake or taken branch in the same cycle SHALL still update PC, flush_o and the counter.
REQ-030 HALTED SHALL go to RUN when halt_i=0 and en_i=1, and to IDLE when halt_i=0 and en_i=0.
REQ-031 taken_cnt_o SHALL increment by one per taken branch and saturate at 16'hFFFF.

Reset
REQ-032 While rst_i=1 at a clock edge, the block SHALL set: state IDLE, PC RESET_PC, fetch_valid_o 0, flush_o 0, misalign_o 0, taken_cnt_o 0.
REQ-033 Reset SHALL override every simultaneous input, including a handshake or a taken branch.
REQ-034 Reset asserted mid-RUN or mid-FLUSH SHALL cancel any pending flush pulse.

Structure
REQ-035 The state enum pc_state_e and the default RESET_PC SHALL live in the shared package cpu_pkg.
REQ-036 The 16-bit saturating counter SHALL be a sub-module named sat_cnt with a WIDTH parameter.
REQ-037 All outputs SHALL be driven directly from registers, with no combinational input-to-output path.

Verification
REQ-038 Reset, then en_i=1 with fetch_ready_i=1 for 3 cycles -> fetch_pc_o sequence 0,4,8, then 12 with fetch_valid_o=1.
REQ-039 fetch_ready_i=0 for 5 cycles at PC=8 -> fetch_pc_o holds 8 with fetch_valid_o=1; release -> 8 is accepted, then 12.
REQ-040 Taken branch with target 'h100 during a handshake at PC=12 -> next cycle flush_o=1 and fetch_valid_o=0; following cycle fetch_pc_o='h100; taken_cnt_o=1.
REQ-041 Taken branch with target 'h103 -> PC='h100 and misalign_o=1, still set after 10 idle cycles.
REQ-042 PC='hFFFF_FFFC with handshake -> PC=0; br_valid_i=1 with br_cond_i=0 -> no flush, counter unchanged.
REQ-043 halt_i together with a taken branch at PC=0 (target 'h40) -> PC='h40, flush_o pulses, state HALTED with fetch_valid_o=0; with halt_i=0 and en_i=1 -> RUN at 'h40.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC generator state encoding and the default reset PC.
package cpu_pkg;

   // PC generator control states. Only ST_RUN presents a valid fetch address.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_HALTED = 2'd3
   } pc_state_e;

   // PC value loaded by reset unless the instantiating design overrides it.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch and branch-resolution bus between the PC generator and the pipeline.
//
// Handshake: the PC generator drives fetch_valid_o/fetch_pc_o from registers.
// A fetch is accepted on a rising clk edge where fetch_valid_o && fetch_ready_i;
// while fetch_valid_o is high and fetch_ready_i is low, fetch_pc_o is held
// stable unless a taken branch, halt or loss of enable retracts the request.
// Branch resolution is a one-cycle strobe: br_valid_i with br_cond_i and
// br_target_i sampled on the same edge; there is no back-pressure on it.
interface pc_gen_if #(
   parameter int DATAWIDTH = 32
);
   logic                 fetch_valid_o;
   logic [DATAWIDTH-1:0] fetch_pc_o;
   logic                 fetch_ready_i;
   logic                 br_valid_i;
   logic                 br_cond_i;
   logic [DATAWIDTH-1:0] br_target_i;

   // PC generator side.
   modport master (
      output fetch_valid_o,
      output fetch_pc_o,
      input  fetch_ready_i,
      input  br_valid_i,
      input  br_cond_i,
      input  br_target_i
   );

   // Pipeline side (fetch stage and branch resolver).
   modport slave (
      input  fetch_valid_o,
      input  fetch_pc_o,
      output fetch_ready_i,
      output br_valid_i,
      output br_cond_i,
      output br_target_i
   );
endinterface

// File: rtl/pc_gen_sat_cnt.sv
// Saturating up-counter: counts increment strobes and sticks at all-ones.
module sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   // Count register: synchronous clear, increment until all-ones then hold.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch addresses, branch redirect with
// flush pulse, halt handling, sticky misalignment flag and taken-branch count.
module pc_gen
   import cpu_pkg::*;
#(
   parameter int                   DATAWIDTH   = 32,
   parameter logic [DATAWIDTH-1:0] RESET_PC    = DATAWIDTH'(DEFAULT_RESET_PC),
   parameter int                   INSTR_BYTES = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      en_i,
   input  logic      halt_i,
   pc_gen_if.master  fetch_bus,
   output logic      flush_o,
   output logic      misalign_o,
   output logic [15:0] taken_cnt_o,
   output pc_state_e o_dbg_state
);

   // INSTR_BYTES is a power of two, so the alignment bits are a simple mask.
   localparam logic [DATAWIDTH-1:0] ALIGN_MASK = DATAWIDTH'(INSTR_BYTES - 1);
   localparam logic [DATAWIDTH-1:0] PC_STEP    = DATAWIDTH'(INSTR_BYTES);

   pc_state_e            r_state;
   pc_state_e            w_next_state;
   logic [DATAWIDTH-1:0] r_pc;
   logic [DATAWIDTH-1:0] w_next_pc;
   logic                 r_valid;
   logic                 r_flush;
   logic                 r_misalign;
   logic                 w_redirect_ok;
   logic                 w_taken;
   logic                 w_handshake;
   logic                 w_target_misaligned;
   logic [DATAWIDTH-1:0] w_target_aligned;

   // Branches only count while the pipeline is live (RUN or FLUSH).
   assign w_redirect_ok       = (r_state == ST_RUN) || (r_state == ST_FLUSH);
   assign w_taken             = w_redirect_ok && fetch_bus.br_valid_i && fetch_bus.br_cond_i;
   // r_valid is high exactly in RUN, so this is the accepted-fetch condition.
   assign w_handshake         = r_valid && fetch_bus.fetch_ready_i;
   assign w_target_aligned    = fetch_bus.br_target_i & ~ALIGN_MASK;
   assign w_target_misaligned = |(fetch_bus.br_target_i & ALIGN_MASK);

   // Next-state logic: halt beats flush, flush beats dropping enable.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (en_i) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (halt_i)       w_next_state = ST_HALTED;
            else if (w_taken) w_next_state = ST_FLUSH;
            else if (!en_i)   w_next_state = ST_IDLE;
         end
         ST_FLUSH: begin
            if (halt_i)       w_next_state = ST_HALTED;
            else if (w_taken) w_next_state = ST_FLUSH;
            else              w_next_state = ST_RUN;
         end
         ST_HALTED: begin
            if (!halt_i) w_next_state = en_i ? ST_RUN : ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Next-PC select: a taken redirect wins over a same-cycle increment.
   always_comb begin
      w_next_pc = r_pc;
      if (w_taken) begin
         w_next_pc = w_target_aligned;
      end else if (w_handshake) begin
         w_next_pc = r_pc + PC_STEP;
      end
   end

   // State register; fetch_valid is registered alongside so it is a pure flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_valid <= (w_next_state == ST_RUN);
      end
   end

   // PC, flush pulse and sticky misalignment flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc       <= RESET_PC;
         r_flush    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_pc    <= w_next_pc;
         r_flush <= w_taken;
         if (w_taken && w_target_misaligned) begin
            r_misalign <= 1'b1;
         end
      end
   end

   sat_cnt #(
      .WIDTH (16)
   ) u_taken_cnt (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_inc (w_taken),
      .o_cnt (taken_cnt_o)
   );

   assign fetch_bus.fetch_valid_o = r_valid;
   assign fetch_bus.fetch_pc_o    = r_pc;
   assign flush_o                 = r_flush;
   assign misalign_o              = r_misalign;
   assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized traffic against a
// rule-level reference model.
module tb_pc_gen;
   import cpu_pkg::*;

   localparam int          DW   = 32;
   localparam logic [31:0] STEP = 32'd4;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_FLUSH  = 2;
   localparam int M_HALTED = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        halt;
   logic        flush;
   logic        mis;
   logic [15:0] cnt;
   pc_state_e   dbg;

   logic        s_rst;
   logic        s_inc;
   logic [3:0]  s_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state.
   int          m_mode;
   logic [31:0] m_pc;
   logic        m_flush;
   logic        m_mis;
   int          m_cnt;

   pc_gen_if #(.DATAWIDTH(DW)) bus ();

   pc_gen #(
      .DATAWIDTH   (DW),
      .RESET_PC    (32'h0000_0000),
      .INSTR_BYTES (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .halt_i      (halt),
      .fetch_bus   (bus),
      .flush_o     (flush),
      .misalign_o  (mis),
      .taken_cnt_o (cnt),
      .o_dbg_state (dbg)
   );

   sat_cnt #(.WIDTH(4)) u_sat (
      .i_clk (clk),
      .i_rst (s_rst),
      .i_inc (s_inc),
      .o_cnt (s_cnt)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   function automatic pc_state_e mode_to_state(input int mode);
      case (mode)
         M_RUN:    return ST_RUN;
         M_FLUSH:  return ST_FLUSH;
         M_HALTED: return ST_HALTED;
         default:  return ST_IDLE;
      endcase
   endfunction

   // Reference model: applies the block's rules to the inputs seen at one edge.
   task automatic model_edge();
      bit taken;
      bit accepted;
      if (rst) begin
         m_mode = M_IDLE; m_pc = 32'h0; m_flush = 1'b0; m_mis = 1'b0; m_cnt = 0;
         return;
      end
      taken    = ((m_mode == M_RUN) || (m_mode == M_FLUSH)) && bus.br_valid_i && bus.br_cond_i;
      accepted = (m_mode == M_RUN) && bus.fetch_ready_i;
      if (taken) begin
         m_pc = bus.br_target_i - (bus.br_target_i % STEP);
         if ((bus.br_target_i % STEP) != 32'd0) m_mis = 1'b1;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (accepted) begin
         m_pc = m_pc + STEP;
      end
      m_flush = taken;
      case (m_mode)
         M_IDLE:   if (en) m_mode = M_RUN;
         M_RUN:    if (halt) m_mode = M_HALTED; else if (taken) m_mode = M_FLUSH; else if (!en) m_mode = M_IDLE;
         M_FLUSH:  if (halt) m_mode = M_HALTED; else if (taken) m_mode = M_FLUSH; else m_mode = M_RUN;
         default:  if (!halt) m_mode = en ? M_RUN : M_IDLE;
      endcase
   endtask

   // One clock: inputs are already driven; update the model and settle.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive_quiet();
      rst = 1'b0; en = 1'b0; halt = 1'b0;
      bus.fetch_ready_i = 1'b0; bus.br_valid_i = 1'b0; bus.br_cond_i = 1'b0; bus.br_target_i = '0;
   endtask

   task automatic do_reset();
      drive_quiet();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drive_quiet();
      rst = 1'b1; en = 1'b1; bus.fetch_ready_i = 1'b1;
      bus.br_valid_i = 1'b1; bus.br_cond_i = 1'b1; bus.br_target_i = 32'h203;
      step();
      tests_run++; if (dbg !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg, ST_IDLE); end
      tests_run++; if (bus.fetch_pc_o !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected %h", bus.fetch_pc_o, 32'h0); end
      tests_run++; if (bus.fetch_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.fetch_valid_o); end
      tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %b expected 0", flush); end
      tests_run++; if (mis !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign: got %b expected 0", mis); end
      tests_run++; if (cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_cnt: got %h expected 0", cnt); end
   endtask

   task automatic test_fetch_seq();
      logic [31:0] exp_seq [4];
      exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
      do_reset();
      en = 1'b1; bus.fetch_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         tests_run++; if (bus.fetch_pc_o !== exp_seq[i]) begin tests_failed++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, bus.fetch_pc_o, exp_seq[i]); end
         tests_run++; if (bus.fetch_valid_o !== 1'b1) begin tests_failed++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, bus.fetch_valid_o); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      en = 1'b1; bus.fetch_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      bus.fetch_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++; if (bus.fetch_pc_o !== 32'h8) begin tests_failed++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, bus.fetch_pc_o, 32'h8); end
         tests_run++; if (bus.fetch_valid_o !== 1'b1) begin tests_failed++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.fetch_valid_o); end
      end
      bus.fetch_ready_i = 1'b1;
      step();
      tests_run++; if (bus.fetch_pc_o !== 32'hC) begin tests_failed++; $display("FAIL stall_release_pc: got %h expected %h", bus.fetch_pc_o, 32'hC); end
   endtask

   task automatic test_branch_and_misalign();
      do_reset();
      en = 1'b1; bus.fetch_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) step();
      bus.br_valid_i = 1'b1; bus.br_cond_i = 1'b1; bus.br_target_i = 32'h100;
      step();
      tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL br_flush: got %b expected 1", flush); end
      tests_run++; if (bus.fetch_valid_o !== 1'b0) begin tests_failed++; $display("FAIL br_valid: got %b expected 0", bus.fetch_valid_o); end
      tests_run++; if (dbg !== ST_FLUSH) begin tests_failed++; $display("FAIL br_state: got %0d expected %0d", dbg, ST_FLUSH); end
      bus.br_valid_i = 1'b0;
      step();
      tests_run++; if (bus.fetch_pc_o !== 32'h100) begin tests_failed++; $display("FAIL br_pc: got %h expected %h", bus.fetch_pc_o, 32'h100); end
      tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL br_flush_end: got %b expected 0", flush); end
      tests_run++; if (bus.fetch_valid_o !== 1'b1) begin tests_failed++; $display("FAIL br_resume: got %b expected 1", bus.fetch_valid_o); end
      tests_run++; if (cnt !== 16'd1) begin tests_failed++; $display("FAIL br_cnt: got %0d expected 1", cnt); end
      // Misaligned target: low bits dropped, sticky flag raised.
      bus.fetch_ready_i = 1'b0;
      bus.br_valid_i = 1'b1; bus.br_cond_i = 1'b1; bus.br_target_i = 32'h103;
      step();
      tests_run++; if (mis !== 1'b1) begin tests_failed++; $display("FAIL mis_set: got %b expected 1", mis); end
      bus.br_valid_i = 1'b0; en = 1'b0;
      for (int i = 0; i < 10; i++) step();
      tests_run++; if (mis !== 1'b1) begin tests_failed++; $display("FAIL mis_sticky: got %b expected 1", mis); end
      tests_run++; if (bus.fetch_pc_o !== 32'h100) begin tests_failed++; $display("FAIL mis_pc: got %h expected %h", bus.fetch_pc_o, 32'h100); end
      tests_run++; if (dbg !== ST_IDLE) begin tests_failed++; $display("FAIL mis_idle: got %0d expected %0d", dbg, ST_IDLE); end
      tests_run++; if (cnt !== 16'd2) begin tests_failed++; $display("FAIL mis_cnt: got %0d expected 2", cnt); end
   endtask

   task automatic test_wrap_and_halt();
      do_reset();
      en = 1'b1;
      step();
      bus.br_valid_i = 1'b1; bus.br_cond_i = 1'b1; bus.br_target_i = 32'hFFFF_FFFC;
      step();
      bus.br_valid_i = 1'b0;
      step();
      tests_run++; if (bus.fetch_pc_o !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pre: got %h expected %h", bus.fetch_pc_o, 32'hFFFF_FFFC); end
      bus.fetch_ready_i = 1'b1;
      step();
      tests_run++; if (bus.fetch_pc_o !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc: got %h expected %h", bus.fetch_pc_o, 32'h0); end
      // Not-taken branch: no redirect, no flush, no count.
      bus.fetch_ready_i = 1'b0;
      bus.br_valid_i = 1'b1; bus.br_cond_i = 1'b0; bus.br_target_i = 32'h500;
      for (int i = 0; i < 2; i++) begin
         step();
         tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL nt_flush[%0d]: got %b expected 0", i, flush); end
         tests_run++; if (cnt !== 16'd1) begin tests_failed++; $display("FAIL nt_cnt[%0d]: got %0d expected 1", i, cnt); end
         tests_run++; if (bus.fetch_pc_o !== 32'h0) begin tests_failed++; $display("FAIL nt_pc[%0d]: got %h expected 0", i, bus.fetch_pc_o); end
      end
      // Halt together with a taken branch and a handshake at PC 0.
      halt = 1'b1; bus.fetch_ready_i = 1'b1;
      bus.br_valid_i = 1'b1; bus.br_cond_i = 1'b1; bus.br_target_i = 32'h40;
      step();
      tests_run++; if (bus.fetch_pc_o !== 32'h40) begin tests_failed++; $display("FAIL halt_pc: got %h expected %h", bus.fetch_pc_o, 32'h40); end
      tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL halt_flush: got %b expected 1", flush); end
      tests_run++; if (dbg !== ST_HALTED) begin tests_failed++; $display("FAIL halt_state: got %0d expected %0d", dbg, ST_HALTED); end
      tests_run++; if (bus.fetch_valid_o !== 1'b0) begin tests_failed++; $display("FAIL halt_valid: got %b expected 0", bus.fetch_valid_o); end
      tests_run++; if (cnt !== 16'd2) begin tests_failed++; $display("FAIL halt_cnt: got %0d expected 2", cnt); end
      // Branch while HALTED is ignored.
      bus.br_target_i = 32'h80;
      step();
      tests_run++; if (bus.fetch_pc_o !== 32'h40) begin tests_failed++; $display("FAIL halted_br_pc: got %h expected %h", bus.fetch_pc_o, 32'h40); end
      tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL halted_br_flush: got %b expected 0", flush); end
      tests_run++; if (cnt !== 16'd2) begin tests_failed++; $display("FAIL halted_br_cnt: got %0d expected 2", cnt); end
      bus.br_valid_i = 1'b0; bus.fetch_ready_i = 1'b0; halt = 1'b0; en = 1'b1;
      step();
      tests_run++; if (dbg !== ST_RUN) begin tests_failed++; $display("FAIL unhalt_state: got %0d expected %0d", dbg, ST_RUN); end
      tests_run++; if (bus.fetch_pc_o !== 32'h40) begin tests_failed++; $display("FAIL unhalt_pc: got %h expected %h", bus.fetch_pc_o, 32'h40); end
      tests_run++; if (bus.fetch_valid_o !== 1'b1) begin tests_failed++; $display("FAIL unhalt_valid: got %b expected 1", bus.fetch_valid_o); end
      halt = 1'b1;
      step();
      halt = 1'b0; en = 1'b0;
      step();
      tests_run++; if (dbg !== ST_IDLE) begin tests_failed++; $display("FAIL unhalt_idle: got %0d expected %0d", dbg, ST_IDLE); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      // A branch in IDLE is ignored.
      bus.br_valid_i = 1'b1; bus.br_cond_i = 1'b1; bus.br_target_i = 32'h70;
      step();
      tests_run++; if (bus.fetch_pc_o !== 32'h0 || cnt !== 16'd0 || flush !== 1'b0) begin
         tests_failed++; $display("FAIL idle_br: got pc %h cnt %0d flush %b expected pc 0 cnt 0 flush 0", bus.fetch_pc_o, cnt, flush);
      end
      bus.br_valid_i = 1'b0; en = 1'b1;
      step();
      bus.br_valid_i = 1'b1; bus.br_target_i = 32'h10;
      step();
      bus.br_target_i = 32'h20;
      step();
      tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL b2b_flush: got %b expected 1", flush); end
      tests_run++; if (dbg !== ST_FLUSH) begin tests_failed++; $display("FAIL b2b_state: got %0d expected %0d", dbg, ST_FLUSH); end
      tests_run++; if (bus.fetch_pc_o !== 32'h20) begin tests_failed++; $display("FAIL b2b_pc: got %h expected %h", bus.fetch_pc_o, 32'h20); end
      bus.br_valid_i = 1'b0;
      step();
      tests_run++; if (dbg !== ST_RUN || flush !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got state %0d flush %b expected state %0d flush 0", dbg, flush, ST_RUN); end
      tests_run++; if (cnt !== 16'd2) begin tests_failed++; $display("FAIL b2b_cnt: got %0d expected 2", cnt); end
   endtask

   task automatic test_reset_override();
      do_reset();
      en = 1'b1; bus.fetch_ready_i = 1'b1;
      step(); step();
      bus.br_valid_i = 1'b1; bus.br_cond_i = 1'b1; bus.br_target_i = 32'h203;
      step();
      // Mid-FLUSH: reset with a handshake-ready, taken branch and halt all present.
      rst = 1'b1; halt = 1'b1; bus.br_target_i = 32'h301;
      step();
      tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL rstov_flush: got %b expected 0", flush); end
      tests_run++; if (bus.fetch_pc_o !== 32'h0) begin tests_failed++; $display("FAIL rstov_pc: got %h expected 0", bus.fetch_pc_o); end
      tests_run++; if (cnt !== 16'd0 || mis !== 1'b0) begin tests_failed++; $display("FAIL rstov_cnt_mis: got cnt %0d mis %b expected 0 0", cnt, mis); end
      tests_run++; if (dbg !== ST_IDLE) begin tests_failed++; $display("FAIL rstov_state: got %0d expected %0d", dbg, ST_IDLE); end
      drive_quiet();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 149) == 0);
         en   = ($urandom_range(0, 9) != 0);
         halt = ($urandom_range(0, 24) == 0);
         bus.fetch_ready_i = 1'($urandom_range(0, 1));
         bus.br_valid_i    = ($urandom_range(0, 3) == 0);
         bus.br_cond_i     = 1'($urandom_range(0, 1));
         bus.br_target_i   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
         step();
         tests_run++; if (bus.fetch_pc_o !== m_pc) begin tests_failed++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, bus.fetch_pc_o, m_pc); end
         tests_run++; if (bus.fetch_valid_o !== (m_mode == M_RUN)) begin tests_failed++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.fetch_valid_o, (m_mode == M_RUN)); end
         tests_run++; if (flush !== m_flush) begin tests_failed++; $display("FAIL rnd_flush[%0d]: got %b expected %b", i, flush, m_flush); end
         tests_run++; if (mis !== m_mis) begin tests_failed++; $display("FAIL rnd_mis[%0d]: got %b expected %b", i, mis, m_mis); end
         tests_run++; if (cnt !== 16'(m_cnt)) begin tests_failed++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, cnt, m_cnt); end
         tests_run++; if (dbg !== mode_to_state(m_mode)) begin tests_failed++; $display("FAIL rnd_state[%0d]: got %0d expected %0d", i, dbg, mode_to_state(m_mode)); end
      end
      drive_quiet();
   endtask

   task automatic test_saturation();
      int exp_v;
      s_rst = 1'b1; s_inc = 1'b0;
      @(posedge clk); #1;
      s_rst = 1'b0; s_inc = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         exp_v = (i > 15) ? 15 : i;
         tests_run++; if (s_cnt !== 4'(exp_v)) begin tests_failed++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, s_cnt, exp_v); end
      end
      s_inc = 1'b0;
   endtask

   initial begin
      drive_quiet();
      s_rst = 1'b1; s_inc = 1'b0;
      test_reset();
      test_fetch_seq();
      test_stall();
      test_branch_and_misalign();
      test_wrap_and_halt();
      test_back_to_back();
      test_reset_override();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
